// File: rtl/axi_10g_ethernet_0_pkg.sv
// Shared types and helpers for the RX payload checksum path.
package axi_10g_ethernet_0_pkg;

    typedef enum logic [2:0] {
        ACCUM    = 3'd0,
        WAIT_EXP = 3'd1,
        FOLD1    = 3'd2,
        FOLD2    = 3'd3,
        OUTPUT   = 3'd4
    } csum_state_e;

    // Byte 2k becomes the high octet of 16-bit word k (network byte order).
    function automatic logic [63:0] word_swap(input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            r[16*k +: 16] = {d[16*k +: 8], d[16*k+8 +: 8]};
        end
        return r;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // Two end-around carry passes bring an 18-bit partial sum down to 16 bits.
    function automatic logic [15:0] ones_fold18(input logic [17:0] t1);
        logic [16:0] t2;
        t2 = {1'b0, t1[15:0]} + {15'b0, t1[17:16]};
        return t2[15:0] + {15'b0, t2[16]};
    endfunction

endpackage

// File: rtl/axi_10g_ethernet_0_rx_checksum_if.sv
// Tapped RX beat, expected-sum and result handshakes of the RX checksum block.
interface axi_10g_ethernet_0_rx_checksum_if;

    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        exp_valid;
    logic        exp_ready;
    logic [15:0] exp_data;
    logic        res_valid;
    logic        res_ready;
    logic        res_ok;
    logic [15:0] res_sum;

    modport slave (
        input  s_axis_tvalid, s_axis_tready, s_axis_tdata, s_axis_tkeep,
        input  exp_valid, exp_data, res_ready,
        output exp_ready, res_valid, res_ok, res_sum
    );

    modport master (
        output s_axis_tvalid, s_axis_tready, s_axis_tdata, s_axis_tkeep,
        output exp_valid, exp_data, res_ready,
        input  exp_ready, res_valid, res_ok, res_sum
    );

endinterface

// File: rtl/axi_10g_ethernet_0_csum_beat_adder.sv
// P1 stage: masks disabled bytes, sums the four big-endian words of a beat, counts kept bytes.
module axi_10g_ethernet_0_csum_beat_adder
    import axi_10g_ethernet_0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [63:0] i_data,
    input  logic [7:0]  i_keep,
    output logic        o_valid,
    output logic [17:0] o_sum,
    output logic [3:0]  o_cnt
);

    logic [63:0] w_masked;
    logic [63:0] w_words;
    logic [17:0] w_sum;

    always_comb begin
        w_masked = '0;
        for (int unsigned n = 0; n < 8; n++) begin
            w_masked[8*n +: 8] = i_keep[n] ? i_data[8*n +: 8] : 8'h00;
        end
        w_words = word_swap(w_masked);
        w_sum   = {2'b00, w_words[15:0]}  + {2'b00, w_words[31:16]}
                + {2'b00, w_words[47:32]} + {2'b00, w_words[63:48]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_cnt   <= '0;
        end else begin
            o_valid <= i_en;
            if (i_en) begin
                o_sum <= w_sum;
                o_cnt <= popcount8(i_keep);
            end
        end
    end

endmodule

// File: rtl/axi_10g_ethernet_0_rx_checksum.sv
// RX payload checksum: accumulates each fixed-length segment, folds it with the
// header parser's expected sum and reports one pass/fail result per segment.
module axi_10g_ethernet_0_rx_checksum
    import axi_10g_ethernet_0_pkg::*;
#(
    parameter int unsigned TCP_DATA_LENGTH = 1456
) (
    input  logic                                  s_aclk,
    input  logic                                  s_areset,
    axi_10g_ethernet_0_rx_checksum_if.slave       bus,
    output logic                                  stall,
    output logic                                  err_overrun
);

    localparam logic [16:0] SEG_LEN = 17'(TCP_DATA_LENGTH);

    csum_state_e r_state;
    logic        r_stall;
    logic        r_err;
    logic [15:0] r_rawcnt;
    logic [15:0] r_bytecnt;
    logic [31:0] r_acc;
    logic [15:0] r_exp;
    logic [17:0] r_t1;
    logic        r_seg_ovr;
    logic        r_res_valid;
    logic        r_res_ok;
    logic [15:0] r_res_sum;

    logic        w_beat;
    logic        w_take;
    logic        w_res_hs;
    logic [16:0] w_raw_next;
    logic [16:0] w_p2_next;
    logic        w_p1_valid;
    logic [17:0] w_p1_sum;
    logic [3:0]  w_p1_cnt;
    logic [15:0] w_fold;

    assign w_beat     = bus.s_axis_tvalid & bus.s_axis_tready;
    assign w_take     = w_beat & ~r_stall;
    assign w_res_hs   = r_res_valid & bus.res_ready;
    assign w_raw_next = {1'b0, r_rawcnt} + {13'b0, popcount8(bus.s_axis_tkeep)};
    assign w_p2_next  = {1'b0, r_bytecnt} + {13'b0, w_p1_cnt};
    assign w_fold     = ones_fold18(r_t1);

    axi_10g_ethernet_0_csum_beat_adder u_beat_adder (
        .clk     (s_aclk),
        .rst     (s_areset),
        .i_en    (w_take),
        .i_data  (bus.s_axis_tdata),
        .i_keep  (bus.s_axis_tkeep),
        .o_valid (w_p1_valid),
        .o_sum   (w_p1_sum),
        .o_cnt   (w_p1_cnt)
    );

    // Raw counter mirrors bytecnt one stage early so stall can rise right after the closing beat.
    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            r_rawcnt <= '0;
            r_stall  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (w_take) begin
                if (w_raw_next >= SEG_LEN) begin
                    r_rawcnt <= '0;
                    r_stall  <= 1'b1;
                    if (w_raw_next > SEG_LEN) r_err <= 1'b1;
                end else begin
                    r_rawcnt <= w_raw_next[15:0];
                end
            end
            if (w_beat && r_stall) r_err <= 1'b1;
            if (w_res_hs) r_stall <= 1'b0;
        end
    end

    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_bytecnt   <= '0;
            r_exp       <= '0;
            r_t1        <= '0;
            r_seg_ovr   <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_ok    <= 1'b0;
            r_res_sum   <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_p1_valid) begin
                        r_acc <= r_acc + {14'b0, w_p1_sum};
                        if (w_p2_next >= SEG_LEN) begin
                            r_bytecnt <= '0;
                            r_state   <= WAIT_EXP;
                            if (w_p2_next > SEG_LEN) r_seg_ovr <= 1'b1;
                        end else begin
                            r_bytecnt <= w_p2_next[15:0];
                        end
                    end
                end
                WAIT_EXP: begin
                    if (bus.exp_valid) begin
                        r_exp   <= bus.exp_data;
                        r_state <= FOLD1;
                    end
                end
                FOLD1: begin
                    r_t1    <= {2'b00, r_acc[15:0]} + {2'b00, r_acc[31:16]} + {2'b00, r_exp};
                    r_state <= FOLD2;
                end
                FOLD2: begin
                    r_res_sum   <= w_fold;
                    r_res_ok    <= (w_fold == 16'hFFFF) & ~r_seg_ovr;
                    r_res_valid <= 1'b1;
                    r_state     <= OUTPUT;
                end
                OUTPUT: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_acc       <= '0;
                        r_seg_ovr   <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

    assign bus.exp_ready = (r_state == WAIT_EXP);
    assign bus.res_valid = r_res_valid;
    assign bus.res_ok    = r_res_ok;
    assign bus.res_sum   = r_res_sum;
    assign stall         = r_stall;
    assign err_overrun   = r_err;

endmodule

// File: tb/tb_axi_10g_ethernet_0_rx_checksum.sv
// Scoreboard bench for the RX checksum block; two instances cover the 1456 and 1455 byte segment lengths.
module tb_axi_10g_ethernet_0_rx_checksum;

    typedef struct packed {
        logic [15:0] sum;
        logic        ok;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sel;
    logic        tvalid, tready, exp_valid, res_ready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic [15:0] exp_data;
    logic        stall0, stall1, ovr0, ovr1;

    axi_10g_ethernet_0_rx_checksum_if bus0 ();
    axi_10g_ethernet_0_rx_checksum_if bus1 ();

    assign bus0.s_axis_tvalid = tvalid & ~sel;
    assign bus1.s_axis_tvalid = tvalid & sel;
    assign bus0.s_axis_tready = tready;
    assign bus1.s_axis_tready = tready;
    assign bus0.s_axis_tdata  = tdata;
    assign bus1.s_axis_tdata  = tdata;
    assign bus0.s_axis_tkeep  = tkeep;
    assign bus1.s_axis_tkeep  = tkeep;
    assign bus0.exp_valid     = exp_valid & ~sel;
    assign bus1.exp_valid     = exp_valid & sel;
    assign bus0.exp_data      = exp_data;
    assign bus1.exp_data      = exp_data;
    assign bus0.res_ready     = res_ready;
    assign bus1.res_ready     = res_ready;

    axi_10g_ethernet_0_rx_checksum #(.TCP_DATA_LENGTH(1456)) u_dut0 (
        .s_aclk      (clk),
        .s_areset    (rst),
        .bus         (bus0),
        .stall       (stall0),
        .err_overrun (ovr0)
    );

    axi_10g_ethernet_0_rx_checksum #(.TCP_DATA_LENGTH(1455)) u_dut1 (
        .s_aclk      (clk),
        .s_areset    (rst),
        .bus         (bus1),
        .stall       (stall1),
        .err_overrun (ovr1)
    );

    wire        w_stall     = sel ? stall1 : stall0;
    wire        w_res_valid = sel ? bus1.res_valid : bus0.res_valid;
    wire        w_res_ok    = sel ? bus1.res_ok : bus0.res_ok;
    wire [15:0] w_res_sum   = sel ? bus1.res_sum : bus0.res_sum;
    wire        w_exp_ready = sel ? bus1.exp_ready : bus0.exp_ready;

    int   n_vec = 0, n_miss = 0;
    int   n_res0 = 0, n_res1 = 0, n_push0 = 0, n_push1 = 0;
    res_t q0[$];
    res_t q1[$];
    logic [63:0] bd[$];
    logic [7:0]  bk[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus0.res_valid && bus0.res_ready) begin : mon0
            res_t e;
            n_res0++;
            if (q0.size() == 0) check("dut0 unexpected result", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                check("dut0 res_sum", {16'h0, bus0.res_sum}, {16'h0, e.sum});
                check("dut0 res_ok", {31'h0, bus0.res_ok}, {31'h0, e.ok});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus1.res_valid && bus1.res_ready) begin : mon1
            res_t e;
            n_res1++;
            if (q1.size() == 0) check("dut1 unexpected result", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                check("dut1 res_sum", {16'h0, bus1.res_sum}, {16'h0, e.sum});
                check("dut1 res_ok", {31'h0, bus1.res_ok}, {31'h0, e.ok});
            end
        end
    end

    // Reference: running end-around-carry sum of big-endian words, then the expected value.
    function automatic logic [16:0] oc_add(input logic [16:0] s, input logic [15:0] w);
        logic [16:0] t;
        t = s + {1'b0, w};
        if (t[16]) t = t - 17'h0FFFF;
        return t;
    endfunction

    function automatic res_t model(input logic [15:0] e_exp, input int unsigned len);
        res_t        r;
        logic [16:0] s;
        logic [7:0]  hi, lo;
        int unsigned bytes;
        logic [63:0] d;
        logic [7:0]  k;
        s = '0;
        bytes = 0;
        for (int i = 0; i < bd.size(); i++) begin
            d = bd[i];
            k = bk[i];
            for (int w = 0; w < 4; w++) begin
                hi = k[2*w]   ? d[16*w +: 8]   : 8'h00;
                lo = k[2*w+1] ? d[16*w+8 +: 8] : 8'h00;
                s = oc_add(s, {hi, lo});
            end
            bytes += $countones(k);
        end
        s = oc_add(s, e_exp);
        r.sum = s[15:0];
        r.ok  = (s[15:0] == 16'hFFFF) && (bytes <= len);
        return r;
    endfunction

    task automatic fill(input int n, input logic [63:0] d, input logic [7:0] k);
        bd.delete();
        bk.delete();
        repeat (n) begin
            bd.push_back(d);
            bk.push_back(k);
        end
    endtask

    function automatic int qsz();
        return sel ? q1.size() : q0.size();
    endfunction

    // Returns one cycle after the closing beat's handshake.
    task automatic send_seg(input logic [15:0] e_exp, input int unsigned len, output res_t e);
        e = model(e_exp, len);
        if (sel) begin q1.push_back(e); n_push1++; end
        else begin q0.push_back(e); n_push0++; end
        exp_data = e_exp;
        for (int i = 0; i < 50 && w_stall; i++) begin
            @(posedge clk); #1;
        end
        check("stall low before segment", {31'h0, w_stall}, 32'd0);
        for (int i = 0; i < bd.size(); i++) begin
            tvalid = 1'b1;
            tready = 1'b1;
            tdata  = bd[i];
            tkeep  = bk[i];
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && qsz() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("result drained", qsz(), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        res_t e;
        int   lat;
        rst = 1'b1; sel = 1'b0; tvalid = 1'b0; tready = 1'b0; tdata = '0; tkeep = '0;
        exp_valid = 1'b0; exp_data = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset stall", {31'h0, stall0}, 32'd0);
        check("reset res_valid", {31'h0, bus0.res_valid}, 32'd0);
        check("reset exp_ready", {31'h0, bus0.exp_ready}, 32'd0);
        check("reset err_overrun", {31'h0, ovr0}, 32'd0);
        check("reset res_sum", {16'h0, bus0.res_sum}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero segment: latency and stall window.
        exp_valid = 1'b1;
        fill(182, 64'h0, 8'hFF);
        send_seg(16'hFFFF, 1456, e);
        check("stall after last beat", {31'h0, w_stall}, 32'd1);
        lat = 1;
        while (!w_res_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        check("result latency", lat, 32'd5);
        check("stall with result", {31'h0, w_stall}, 32'd1);
        @(posedge clk); #1;
        check("stall after handshake", {31'h0, w_stall}, 32'd0);
        wait_done();

        fill(182, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        send_seg(16'h0000, 1456, e);
        wait_done();

        fill(182, 64'h0, 8'hFF);
        bd[0] = 64'h1;
        send_seg(16'hFEFF, 1456, e);
        wait_done();
        send_seg(16'hFEFE, 1456, e);
        wait_done();

        // Late expected value, then a held-off result consumer.
        exp_valid = 1'b0;
        res_ready = 1'b0;
        fill(182, 64'h0, 8'hFF);
        bd[0] = 64'h0123_4567_89AB_CDEF;
        bd[1] = 64'h5A5A_0000_FFFF_1357;
        send_seg(16'h1234, 1456, e);
        check("exp_ready in P2 cycle", {31'h0, w_exp_ready}, 32'd0);
        repeat (10) begin @(posedge clk); #1; end
        check("exp_ready waiting", {31'h0, w_exp_ready}, 32'd1);
        check("stall waiting exp", {31'h0, w_stall}, 32'd1);
        exp_valid = 1'b1;
        @(posedge clk); #1;
        exp_valid = 1'b0;
        check("exp_ready after accept", {31'h0, w_exp_ready}, 32'd0);
        for (int i = 0; i < 10 && !w_res_valid; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 20; i++) begin
            check("hold res_valid", {31'h0, w_res_valid}, 32'd1);
            check("hold res_sum", {16'h0, w_res_sum}, {16'h0, e.sum});
            check("hold res_ok", {31'h0, w_res_ok}, {31'h0, e.ok});
            check("hold stall", {31'h0, w_stall}, 32'd1);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        exp_valid = 1'b1;
        wait_done();

        // Reset in the middle of a segment discards the partial sum.
        for (int i = 0; i < 90; i++) begin
            tvalid = 1'b1; tready = 1'b1; tdata = 64'h1111_2222_3333_4444; tkeep = 8'hFF;
            @(posedge clk); #1;
        end
        tvalid = 1'b0;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        check("stall after mid reset", {31'h0, stall0}, 32'd0);
        check("res_valid after mid reset", {31'h0, bus0.res_valid}, 32'd0);
        fill(182, 64'h0, 8'hFF);
        send_seg(16'hFFFF, 1456, e);
        wait_done();
        repeat (20) begin @(posedge clk); #1; end
        check("dut0 result count", n_res0, n_push0);
        check("err_overrun clear", {31'h0, ovr0}, 32'd0);

        // Beat presented while stalled.
        send_seg(16'hFFFF, 1456, e);
        tvalid = 1'b1; tready = 1'b1; tdata = 64'hFFFF_FFFF_FFFF_FFFF; tkeep = 8'hFF;
        @(posedge clk); #1;
        tvalid = 1'b0;
        wait_done();
        check("err_overrun on stalled beat", {31'h0, ovr0}, 32'd1);

        // Odd segment length: padded final byte, then an overrunning segment.
        sel = 1'b1;
        fill(182, 64'h0, 8'hFF);
        bd[181] = 64'h00AB_0000_0000_0000;
        bk[181] = 8'h7F;
        send_seg(16'h54FF, 1455, e);
        wait_done();
        check("dut1 err_overrun clear", {31'h0, ovr1}, 32'd0);

        fill(182, 64'h0, 8'hFF);
        send_seg(16'hFFFF, 1455, e);
        wait_done();
        check("dut1 err_overrun on crossing", {31'h0, ovr1}, 32'd1);
        repeat (10) begin @(posedge clk); #1; end
        check("dut1 result count", n_res1, n_push1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
